// File: rtl/memory_bus_if.sv
// CPU parallel-bus write front-end: registers the bus, turns each CPU write into one
// strobe, routes it to a BRAM region and holds the write-side segment/page registers.
module memory_bus_if #(
    parameter logic [13:0] ADDR_MOD_MEM_WR_SEGMENT = 14'h0020,
    parameter logic [13:0] ADDR_STM_MEM_WR_SEGMENT = 14'h0050,
    parameter logic [13:0] ADDR_STM_MEM_WR_PAGE    = 14'h0051
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        WE,
    input  logic [1:0]  BRAM_SELECT,
    input  logic [13:0] BRAM_ADDR,
    input  logic [15:0] DATA_IN,
    output logic        CNT_WE,
    output logic [13:0] CNT_ADDR,
    output logic [15:0] CNT_DIN,
    output logic        MOD_WE,
    output logic [14:0] MOD_ADDR,
    output logic [15:0] MOD_DIN,
    output logic        PWE_WE,
    output logic [7:0]  PWE_ADDR,
    output logic [15:0] PWE_DIN,
    output logic        STM_WE,
    output logic [18:0] STM_ADDR,
    output logic [15:0] STM_DIN,
    output logic        MOD_WR_SEGMENT,
    output logic        STM_WR_SEGMENT,
    output logic [3:0]  STM_WR_PAGE
);

    logic        req_p0;
    logic [1:0]  sel_p0;
    logic [13:0] addr_p0;
    logic [15:0] din_p0;
    logic        hist_p1;
    logic        wr_start;

    // Stage 1: bus sampling; only the request level is reset so history starts clean
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            req_p0 <= 1'b0;
        end else begin
            req_p0 <= EN & WE;
        end
        sel_p0  <= BRAM_SELECT;
        addr_p0 <= BRAM_ADDR;
        din_p0  <= DATA_IN;
    end

    assign wr_start = req_p0 & ~hist_p1;

    // Stage 2: edge detect, routing and segment/page registers
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            hist_p1        <= 1'b0;
            CNT_WE         <= 1'b0;
            CNT_ADDR       <= '0;
            CNT_DIN        <= '0;
            MOD_WE         <= 1'b0;
            MOD_ADDR       <= '0;
            MOD_DIN        <= '0;
            PWE_WE         <= 1'b0;
            PWE_ADDR       <= '0;
            PWE_DIN        <= '0;
            STM_WE         <= 1'b0;
            STM_ADDR       <= '0;
            STM_DIN        <= '0;
            MOD_WR_SEGMENT <= 1'b0;
            STM_WR_SEGMENT <= 1'b0;
            STM_WR_PAGE    <= '0;
        end else begin
            hist_p1 <= req_p0;
            CNT_WE  <= wr_start && (sel_p0 == 2'd0);
            MOD_WE  <= wr_start && (sel_p0 == 2'd1);
            PWE_WE  <= wr_start && (sel_p0 == 2'd2);
            STM_WE  <= wr_start && (sel_p0 == 2'd3);
            if (wr_start) begin
                case (sel_p0)
                    2'd0: begin
                        CNT_ADDR <= addr_p0;
                        CNT_DIN  <= din_p0;
                        if (addr_p0 == ADDR_MOD_MEM_WR_SEGMENT) MOD_WR_SEGMENT <= din_p0[0];
                        if (addr_p0 == ADDR_STM_MEM_WR_SEGMENT) STM_WR_SEGMENT <= din_p0[0];
                        if (addr_p0 == ADDR_STM_MEM_WR_PAGE)    STM_WR_PAGE    <= din_p0[3:0];
                    end
                    // Segment/page read here are the values held before this edge
                    2'd1: begin
                        MOD_ADDR <= {MOD_WR_SEGMENT, addr_p0};
                        MOD_DIN  <= din_p0;
                    end
                    2'd2: begin
                        PWE_ADDR <= addr_p0[7:0];
                        PWE_DIN  <= din_p0;
                    end
                    default: begin
                        STM_ADDR <= {STM_WR_SEGMENT, STM_WR_PAGE, addr_p0};
                        STM_DIN  <= din_p0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_if.sv
// Bench for memory_bus_if: transaction-level model of CPU writes, strobes collected by a
// monitor and compared per write against addresses composed from the model's registers.
module tb_memory_bus_if;

    localparam logic [13:0] A_MSEG  = 14'h0020;
    localparam logic [13:0] A_SSEG  = 14'h0050;
    localparam logic [13:0] A_SPAGE = 14'h0051;

    logic        BUS_CLK = 1'b0;
    logic        RST, EN, WE;
    logic [1:0]  BRAM_SELECT;
    logic [13:0] BRAM_ADDR;
    logic [15:0] DATA_IN;
    logic        CNT_WE, MOD_WE, PWE_WE, STM_WE;
    logic [13:0] CNT_ADDR;
    logic [14:0] MOD_ADDR;
    logic [7:0]  PWE_ADDR;
    logic [18:0] STM_ADDR;
    logic [15:0] CNT_DIN, MOD_DIN, PWE_DIN, STM_DIN;
    logic        MOD_WR_SEGMENT, STM_WR_SEGMENT;
    logic [3:0]  STM_WR_PAGE;

    memory_bus_if #(
        .ADDR_MOD_MEM_WR_SEGMENT(A_MSEG),
        .ADDR_STM_MEM_WR_SEGMENT(A_SSEG),
        .ADDR_STM_MEM_WR_PAGE(A_SPAGE)
    ) dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .EN(EN), .WE(WE),
        .BRAM_SELECT(BRAM_SELECT), .BRAM_ADDR(BRAM_ADDR), .DATA_IN(DATA_IN),
        .CNT_WE(CNT_WE), .CNT_ADDR(CNT_ADDR), .CNT_DIN(CNT_DIN),
        .MOD_WE(MOD_WE), .MOD_ADDR(MOD_ADDR), .MOD_DIN(MOD_DIN),
        .PWE_WE(PWE_WE), .PWE_ADDR(PWE_ADDR), .PWE_DIN(PWE_DIN),
        .STM_WE(STM_WE), .STM_ADDR(STM_ADDR), .STM_DIN(STM_DIN),
        .MOD_WR_SEGMENT(MOD_WR_SEGMENT), .STM_WR_SEGMENT(STM_WR_SEGMENT),
        .STM_WR_PAGE(STM_WR_PAGE)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int checks = 0;
    int errors = 0;

    // Observed strobes, one entry per strobe-cycle per region
    int          q_reg[$];
    logic [18:0] q_addr[$];
    logic [15:0] q_din[$];

    always @(negedge BUS_CLK) begin
        if (CNT_WE === 1'b1) begin q_reg.push_back(0); q_addr.push_back({5'd0, CNT_ADDR});  q_din.push_back(CNT_DIN); end
        if (MOD_WE === 1'b1) begin q_reg.push_back(1); q_addr.push_back({4'd0, MOD_ADDR});  q_din.push_back(MOD_DIN); end
        if (PWE_WE === 1'b1) begin q_reg.push_back(2); q_addr.push_back({11'd0, PWE_ADDR}); q_din.push_back(PWE_DIN); end
        if (STM_WE === 1'b1) begin q_reg.push_back(3); q_addr.push_back(STM_ADDR);          q_din.push_back(STM_DIN); end
    end

    // Reference model state
    logic        m_mseg, m_sseg;
    logic [3:0]  m_spage;
    logic [18:0] last_addr[4];
    logic [15:0] last_din[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("cnt_we_idle", {28'd0, CNT_WE, MOD_WE, PWE_WE, STM_WE}, 32'd0);
        chk("cnt_addr", {18'd0, CNT_ADDR}, {13'd0, last_addr[0]});
        chk("cnt_din",  {16'd0, CNT_DIN},  {16'd0, last_din[0]});
        chk("mod_addr", {17'd0, MOD_ADDR}, {13'd0, last_addr[1]});
        chk("mod_din",  {16'd0, MOD_DIN},  {16'd0, last_din[1]});
        chk("pwe_addr", {24'd0, PWE_ADDR}, {13'd0, last_addr[2]});
        chk("pwe_din",  {16'd0, PWE_DIN},  {16'd0, last_din[2]});
        chk("stm_addr", {13'd0, STM_ADDR}, {13'd0, last_addr[3]});
        chk("stm_din",  {16'd0, STM_DIN},  {16'd0, last_din[3]});
        chk("mod_seg",  {31'd0, MOD_WR_SEGMENT}, {31'd0, m_mseg});
        chk("stm_seg",  {31'd0, STM_WR_SEGMENT}, {31'd0, m_sseg});
        chk("stm_page", {28'd0, STM_WR_PAGE},    {28'd0, m_spage});
    endtask

    task automatic clear_q();
        q_reg.delete(); q_addr.delete(); q_din.delete();
    endtask

    // One CPU write is expected to have produced exactly one strobe
    task automatic expect_write(input int sel, input logic [13:0] addr, input logic [15:0] data);
        logic [18:0] ea;
        case (sel)
            0: ea = {5'd0, addr};
            1: ea = {4'd0, m_mseg, addr};
            2: ea = {11'd0, addr[7:0]};
            default: ea = {m_sseg, m_spage, addr};
        endcase
        chk("strobe_count", q_reg.size(), 32'd1);
        if (q_reg.size() > 0) begin
            chk("strobe_region", q_reg[0], sel);
            chk("strobe_addr", {13'd0, q_addr[0]}, {13'd0, ea});
            chk("strobe_din", {16'd0, q_din[0]}, {16'd0, data});
        end
        clear_q();
        last_addr[sel] = ea;
        last_din[sel]  = data;
        if (sel == 0) begin
            if (addr == A_MSEG)  m_mseg  = data[0];
            if (addr == A_SSEG)  m_sseg  = data[0];
            if (addr == A_SPAGE) m_spage = data[3:0];
        end
        check_state();
    endtask

    task automatic expect_none();
        chk("no_strobe_count", q_reg.size(), 32'd0);
        clear_q();
        check_state();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic bus_write(input int sel, input logic [13:0] addr, input logic [15:0] data, input int hold);
        @(posedge BUS_CLK); #1;
        EN = 1'b1; WE = 1'b1;
        BRAM_SELECT = 2'(sel); BRAM_ADDR = addr; DATA_IN = data;
        idle(hold);
        EN = 1'b0; WE = 1'b0;
        BRAM_ADDR = 14'($urandom); DATA_IN = 16'($urandom);
        idle(3);
    endtask

    task automatic wr(input int sel, input logic [13:0] addr, input logic [15:0] data, input int hold);
        bus_write(sel, addr, data, hold);
        expect_write(sel, addr, data);
    endtask

    initial begin
        m_mseg = 1'b0; m_sseg = 1'b0; m_spage = 4'd0;
        for (int i = 0; i < 4; i++) begin last_addr[i] = '0; last_din[i] = '0; end

        // Reset held with a write pending on the bus
        RST = 1'b1; EN = 1'b1; WE = 1'b1;
        BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0011; DATA_IN = 16'hC0DE;
        idle(3);
        check_state();
        chk("reset_no_strobe", q_reg.size(), 32'd0);
        clear_q();
        RST = 1'b0;
        idle(4);
        EN = 1'b0; WE = 1'b0;
        idle(3);
        expect_write(0, 14'h0011, 16'hC0DE);

        // Controller write held two cycles
        wr(0, 14'h0005, 16'hBEEF, 2);

        // Modulation segment then modulation write
        wr(0, A_MSEG, 16'hFFF1, 1);
        wr(1, 14'h0003, 16'h1234, 1);
        chk("mod_addr_plan", {17'd0, MOD_ADDR}, 32'h4003);

        // STM segment/page then STM write
        wr(0, A_SSEG, 16'h0001, 1);
        wr(0, A_SPAGE, 16'hABC2, 3);
        wr(3, 14'h0107, 16'hA55A, 2);
        chk("stm_addr_plan", {13'd0, STM_ADDR}, {13'd0, 1'b1, 4'h2, 14'h0107});

        // 256 PWE writes, upper address bits randomised and ignored
        for (int i = 0; i < 256; i++) begin
            logic [13:0] a;
            a = {6'($urandom), 8'(i)};
            wr(2, a, 16'(i), 1);
        end

        // WE with EN low: no strobe, even aimed at a segment register
        @(posedge BUS_CLK); #1;
        EN = 1'b0; WE = 1'b1; BRAM_SELECT = 2'd0; BRAM_ADDR = A_MSEG; DATA_IN = 16'h0000;
        idle(3);
        WE = 1'b0;
        idle(3);
        expect_none();

        // WE first, EN later: a single strobe
        @(posedge BUS_CLK); #1;
        EN = 1'b0; WE = 1'b1; BRAM_SELECT = 2'd3; BRAM_ADDR = 14'h2A5C; DATA_IN = 16'h5EED;
        idle(2);
        EN = 1'b1;
        idle(3);
        EN = 1'b0; WE = 1'b0;
        idle(3);
        expect_write(3, 14'h2A5C, 16'h5EED);

        // Randomised writes including segment/page register hits
        for (int n = 0; n < 80; n++) begin
            int          s;
            logic [13:0] a;
            logic [15:0] d;
            s = int'($urandom_range(0, 3));
            a = 14'($urandom);
            d = 16'($urandom);
            if (s == 0 && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: a = A_MSEG;
                    1: a = A_SSEG;
                    default: a = A_SPAGE;
                endcase
            end
            wr(s, a, d, int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
